sdram_init_refresh: RTL
=======================

// Module: sdram_init_refresh
// PURPOSE
//  Parametrised SDRAM power-up initialisation and auto-refresh engine for sdram_ctrl_top.
//  Runs the JEDEC init sequence: power-up wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE.
//  Then it schedules periodic AUTO REFRESH. Up to MAX_PEND refreshes can be postponed,
//  and all pending refreshes are issued in one burst through a req/gnt handshake with the command arbiter.
// PARAMETERS
//  ADDR_W        11      SDRAM address width
//  BA_W          2       bank address width
//  T_POWERUP     20000   power-up NOP wait, cycles (200us @100MHz)
//  T_RP          2       PRECHARGE to next command, cycles
//  T_RFC         7       AUTO REFRESH to next command, cycles
//  T_MRD         2       LOAD MODE to init_done, cycles
//  INIT_REF_CNT  8       AUTO REFRESH commands in the init sequence (>=2)
//  REF_INTERVAL  1560    cycles per refresh tick (15.6us @100MHz)
//  MAX_PEND      8       max postponed refreshes (1..8)
//  MODE_REG      11'h030 mode register value (CL=3, BL=1, sequential)
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous active-low reset
//  ref_gnt      in   1       arbiter grant; valid only while ref_req=1
//  init_done    out  1       high from the end of init until reset
//  ref_req      out  1       refresh pending, requesting the bus
//  ref_busy     out  1       engine owns the command bus
//  ref_done     out  1       1-cycle pulse when a refresh burst completes
//  ref_overrun  out  1       sticky: tick lost while pending==MAX_PEND
//  sdr_cke      out  1       clock enable
//  sdr_csn/sdr_rasn/sdr_casn/sdr_wen  out 1 each  command bits
//  sdr_addr     out  ADDR_W  address (A10=1 for PRECHARGE ALL; MODE_REG for LOAD MODE)
//  sdr_ba       out  BA_W    bank address, always 0
// BEHAVIOUR
//  - All outputs are registered. Reset values: sdr_cke=0, cmd=NOP {csn,rasn,casn,wen}=0111,
//    addr=0, ba=0, init_done=0, ref_req=0, ref_busy=1, ref_done=0, ref_overrun=0.
//  - Command encodings: NOP=0111, PRE=0010, AREF=0001, LMR=0000.
//  - Each command is driven for exactly 1 cycle, then NOP. Spacing is command-cycle to next-command cycle.
//  - Init FSM: I_WAIT -> I_PRE -> I_REF -> I_LMR -> IDLE.
//    - I_WAIT: sdr_cke=1 from the first cycle after reset release. NOP for T_POWERUP cycles.
//    - I_PRE: PRE with A10=1, then wait T_RP.
//    - I_REF: INIT_REF_CNT x AREF, each followed by T_RFC.
//    - I_LMR: LMR with addr=MODE_REG; T_MRD cycles later init_done=1 and ref_busy=0.
//  - Refresh timer: starts at 0 in the cycle init_done rises and free-runs.
//    At count REF_INTERVAL-1 it ticks and wraps to 0. It never stops.
//  - pending (0..MAX_PEND): +1 on tick, -1 per AREF issued. Tick and AREF in the same cycle: unchanged.
//    Tick at pending==MAX_PEND: pending stays, ref_overrun=1 (sticky).
//  - ref_req = IDLE && pending!=0.
//  - Run FSM: IDLE -> R_PRE -> R_REF -> R_END -> IDLE.
//    - IDLE -> R_PRE: on a cycle with ref_req=1 && ref_gnt=1. Next cycle: ref_req=0, ref_busy=1, PRE-all driven.
//    - R_REF: after T_RP, issue AREF while pending!=0, each followed by T_RFC.
//      A tick arriving during the burst extends it.
//    - R_END: ref_busy=0 and ref_done=1 for 1 cycle, then IDLE.
//  - ref_gnt is ignored outside IDLE and before init_done.
//    The arbiter drives no commands while ref_busy=1.
//  - Async reset at any point: all outputs go to reset values immediately, counters clear,
//    and the full init sequence restarts, including T_POWERUP.
//  - Counter widths: $clog2(max(T_POWERUP,REF_INTERVAL)+1) and $clog2(MAX_PEND+1).
//    Parameters are checked by an elaboration assertion (all T_* >= 1, INIT_REF_CNT >= 2).
// STRUCTURE
//  - Package sdram_pkg: typedef enum logic[3:0] sdr_cmd_e {CMD_NOP, CMD_PRE, CMD_AREF, CMD_LMR}.
//    Also state enum ref_state_e and the A10 precharge-all bit index.
//  - Sub-module sdram_wait_cnt: loadable down-counter (load, value, zero flag).
//    It sequences all T_* waits. Refresh timer and pending counter stay inline.
// TESTING (bench params: T_POWERUP=10, REF_INTERVAL=50, T_RP=2, T_RFC=7, T_MRD=2, INIT_REF_CNT=2, MAX_PEND=4)
//  1 Reset release -> cke=1 next cycle; 10 NOP cycles, then PRE with addr[10]=1.
//    AREF 2 cycles later, second AREF 7 cycles after that, LMR addr=11'h030 7 cycles later;
//    init_done=1 two cycles after LMR.
//  2 ref_gnt tied 1 -> exactly one PRE+AREF per 50 cycles; ref_done pulses once per burst; ref_overrun=0.
//  3 ref_gnt held 0 for 160 cycles -> pending reaches 3. Then grant ->
//    PRE, 3 AREF spaced 7 cycles, ref_req=0 throughout, single ref_done.
//  4 ref_gnt held 0 for 260 cycles -> pending saturates at 4 and ref_overrun=1 (stays 1).
//    After grant: 4 AREF only.
//  5 Tick coincides with an AREF in a burst -> pending unchanged that cycle; burst issues one extra AREF.
//  6 rst_n pulsed low mid-burst -> same cycle: cmd=NOP, cke=0, ref_busy=1, init_done=0.
//    Full scenario-1 sequence repeats after release.
//  Model check: sdram_model_plus (11/32/8) reports no timing violations in any scenario.

Source files
------------

// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_pkg
// Description : Shared types for the SDRAM init/refresh engine: the SDRAM
//               command encoding {csn,rasn,casn,wen}, the engine state
//               encoding and the A10 precharge-all address bit.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_pkg;

  // SDRAM command bits {csn, rasn, casn, wen}
  typedef enum logic [3:0] {
    CMD_NOP  = 4'b0111,
    CMD_PRE  = 4'b0010,
    CMD_AREF = 4'b0001,
    CMD_LMR  = 4'b0000
  } sdr_cmd_e;

  // Init states (S_I_*) run once after reset; refresh states loop forever.
  typedef enum logic [2:0] {
    S_I_WAIT = 3'd0,
    S_I_PRE  = 3'd1,
    S_I_REF  = 3'd2,
    S_I_LMR  = 3'd3,
    S_IDLE   = 3'd4,
    S_R_PRE  = 3'd5,
    S_R_REF  = 3'd6,
    S_R_END  = 3'd7
  } ref_state_e;

  // Address bit that turns PRECHARGE into PRECHARGE ALL
  localparam int c_a10_bit = 10;

endpackage
`default_nettype wire

// File: rtl/sdram_wait_cnt.sv
`default_nettype none
// ============================================================================
// Module      : sdram_wait_cnt
// Description : Loadable down-counter used to time the gaps between SDRAM
//               commands. Counts down to zero and holds there.
// Ports       : clk, rst_n (async, active low), load / load_val (reload),
//               value (current count), zero (value == 0)
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_wait_cnt #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= RST_VAL;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - W'(1);
    end
  end

  assign zero = (value == '0);

endmodule
`default_nettype wire

// File: rtl/sdram_init_refresh.sv
`default_nettype none
// ============================================================================
// Module      : sdram_init_refresh
// Description : SDRAM power-up initialisation (wait, PRECHARGE ALL,
//               INIT_REF_CNT x AUTO REFRESH, LOAD MODE) followed by periodic
//               auto-refresh. Up to MAX_PEND refreshes may be postponed; all
//               pending ones are issued in one burst after ref_req/ref_gnt.
// Ports       : clk, rst_n (async, active low), ref_gnt (arbiter grant)
//               init_done, ref_req, ref_busy, ref_done, ref_overrun (status)
//               sdr_cke, sdr_csn/rasn/casn/wen, sdr_addr, sdr_ba (SDRAM bus)
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_init_refresh
  import sdram_pkg::*;
#(
  parameter int                ADDR_W       = 11,
  parameter int                BA_W         = 2,
  parameter int                T_POWERUP    = 20000,
  parameter int                T_RP         = 2,
  parameter int                T_RFC        = 7,
  parameter int                T_MRD        = 2,
  parameter int                INIT_REF_CNT = 8,
  parameter int                REF_INTERVAL = 1560,
  parameter int                MAX_PEND     = 8,
  parameter logic [ADDR_W-1:0] MODE_REG     = 11'h030
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ref_gnt,
  output logic              init_done,
  output logic              ref_req,
  output logic              ref_busy,
  output logic              ref_done,
  output logic              ref_overrun,
  output logic              sdr_cke,
  output logic              sdr_csn,
  output logic              sdr_rasn,
  output logic              sdr_casn,
  output logic              sdr_wen,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic [BA_W-1:0]   sdr_ba
);

  localparam int c_tmax   = (T_POWERUP > REF_INTERVAL) ? T_POWERUP : REF_INTERVAL;
  localparam int c_cnt_w  = $clog2(c_tmax + 1);
  localparam int c_pend_w = $clog2(MAX_PEND + 1);
  localparam int c_init_w = $clog2(INIT_REF_CNT);

  localparam logic [ADDR_W-1:0] c_addr_pall = ADDR_W'(1) << c_a10_bit;

  if (T_POWERUP < 1 || T_RP < 1 || T_RFC < 1 || T_MRD < 1 || REF_INTERVAL < 1 ||
      INIT_REF_CNT < 2 || MAX_PEND < 1 || MAX_PEND > 8 || ADDR_W < 11 ||
      T_RP > c_tmax || T_RFC > c_tmax || T_MRD > c_tmax) begin : g_bad_params
    $error("sdram_init_refresh: illegal parameter set");
  end

  ref_state_e           r_state;
  sdr_cmd_e             r_cmd;
  logic [c_init_w-1:0]  r_init_left;
  logic [c_cnt_w-1:0]   r_timer;
  logic [c_pend_w-1:0]  r_pending;

  logic                 w_load;
  logic [c_cnt_w-1:0]   w_load_val;
  logic [c_cnt_w-1:0]   w_wait_val;
  logic                 w_wait_zero;
  logic                 w_aref;
  logic                 w_tick;
  logic [c_pend_w-1:0]  w_pending_nxt;

  assign {sdr_csn, sdr_rasn, sdr_casn, sdr_wen} = r_cmd;
  assign sdr_ba = '0;

  // Reset value T_POWERUP makes the counter hit zero in the cycle before
  // PRECHARGE, so power-up NOPs span exactly T_POWERUP cycles.
  sdram_wait_cnt #(
    .W       (c_cnt_w),
    .RST_VAL (c_cnt_w'(T_POWERUP))
  ) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (w_load_val),
    .value    (w_wait_val),
    .zero     (w_wait_zero)
  );

  // The wait counter is reloaded on the same edge that issues a command.
  // Loading T-1 lets the next command land exactly T cycles later.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    w_aref     = 1'b0;
    case (r_state)
      S_I_WAIT: if (w_wait_zero) begin
        w_load     = 1'b1;
        w_load_val = c_cnt_w'(T_RP - 1);
      end
      S_I_PRE: if (w_wait_zero) begin
        w_load     = 1'b1;
        w_load_val = c_cnt_w'(T_RFC - 1);
      end
      S_I_REF: if (w_wait_zero) begin
        w_load     = 1'b1;
        w_load_val = (r_init_left != '0) ? c_cnt_w'(T_RFC - 1) : c_cnt_w'(T_MRD - 1);
      end
      S_IDLE: if (ref_req && ref_gnt) begin
        w_load     = 1'b1;
        w_load_val = c_cnt_w'(T_RP - 1);
      end
      S_R_PRE: if (w_wait_zero) begin
        w_load     = 1'b1;
        w_load_val = c_cnt_w'(T_RFC - 1);
        w_aref     = 1'b1;
      end
      S_R_REF: if (w_wait_zero && r_pending != '0) begin
        w_load     = 1'b1;
        w_load_val = c_cnt_w'(T_RFC - 1);
        w_aref     = 1'b1;
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  assign w_tick = init_done && (r_timer == c_cnt_w'(REF_INTERVAL - 1));

  // Tick and refresh on the same edge cancel out; a tick at the ceiling is lost.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_tick && !w_aref) begin
      if (r_pending != c_pend_w'(MAX_PEND)) begin
        w_pending_nxt = r_pending + c_pend_w'(1);
      end
    end else if (!w_tick && w_aref) begin
      w_pending_nxt = r_pending - c_pend_w'(1);
    end
  end

  // Refresh timer, pending count and overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer     <= '0;
      r_pending   <= '0;
      ref_overrun <= 1'b0;
    end else begin
      if (init_done) begin
        r_timer <= w_tick ? '0 : r_timer + c_cnt_w'(1);
      end
      r_pending <= w_pending_nxt;
      if (w_tick && !w_aref && r_pending == c_pend_w'(MAX_PEND)) begin
        ref_overrun <= 1'b1;
      end
    end
  end

  // Main sequencer. Commands default to NOP so each one lasts a single cycle.
  // ref_req is computed from next-cycle state/pending so that it equals
  // (state == IDLE && pending != 0) in the cycle it is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_I_WAIT;
      r_cmd       <= CMD_NOP;
      r_init_left <= '0;
      sdr_addr    <= '0;
      sdr_cke     <= 1'b0;
      init_done   <= 1'b0;
      ref_req     <= 1'b0;
      ref_busy    <= 1'b1;
      ref_done    <= 1'b0;
    end else begin
      sdr_cke  <= 1'b1;
      r_cmd    <= CMD_NOP;
      sdr_addr <= '0;
      ref_done <= 1'b0;
      case (r_state)
        S_I_WAIT: if (w_wait_zero) begin
          r_cmd    <= CMD_PRE;
          sdr_addr <= c_addr_pall;
          r_state  <= S_I_PRE;
        end
        S_I_PRE: if (w_wait_zero) begin
          r_cmd       <= CMD_AREF;
          r_init_left <= c_init_w'(INIT_REF_CNT - 1);
          r_state     <= S_I_REF;
        end
        S_I_REF: if (w_wait_zero) begin
          if (r_init_left != '0) begin
            r_cmd       <= CMD_AREF;
            r_init_left <= r_init_left - c_init_w'(1);
          end else begin
            r_cmd    <= CMD_LMR;
            sdr_addr <= MODE_REG;
            r_state  <= S_I_LMR;
          end
        end
        S_I_LMR: if (w_wait_zero) begin
          init_done <= 1'b1;
          ref_busy  <= 1'b0;
          ref_req   <= (w_pending_nxt != '0);
          r_state   <= S_IDLE;
        end
        S_IDLE: begin
          if (ref_req && ref_gnt) begin
            r_cmd    <= CMD_PRE;
            sdr_addr <= c_addr_pall;
            ref_busy <= 1'b1;
            ref_req  <= 1'b0;
            r_state  <= S_R_PRE;
          end else begin
            ref_req <= (w_pending_nxt != '0);
          end
        end
        S_R_PRE: if (w_wait_zero) begin
          r_cmd   <= CMD_AREF;
          r_state <= S_R_REF;
        end
        // Pending is re-read after every refresh, so ticks arriving during
        // the burst lengthen it.
        S_R_REF: if (w_wait_zero) begin
          if (r_pending != '0) begin
            r_cmd <= CMD_AREF;
          end else begin
            ref_busy <= 1'b0;
            ref_done <= 1'b1;
            r_state  <= S_R_END;
          end
        end
        S_R_END: begin
          ref_req <= (w_pending_nxt != '0);
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_I_WAIT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
